// File: rtl/motorpasso_key_debounce.sv
// Multi-channel two-flop synchronizer and counter-based debouncer with rise/fall strobes.
// Optional feature macro: KEY_ACTIVE_LOW_INVERT_EN (inverts raw_in ahead of the synchronizer).
module motorpasso_key_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic             busy_q, busy_d;

    // Input polarity ahead of the first synchronizer flop.
    always_comb begin
`ifdef KEY_ACTIVE_LOW_INVERT_EN
        s1_d = ~raw_in;
`else
        s1_d = raw_in;
`endif
    end

    // Per-channel debounce decision: a change is accepted only after a full unbroken mismatch run.
    always_comb begin
        db_d   = db_q;
        rise_d = {WIDTH{1'b0}};
        fall_d = {WIDTH{1'b0}};
        busy_d = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_q[i] == CNT_LAST) begin
                db_d[i]   = s2_q[i];
                cnt_d[i]  = CNT_ZERO;
                rise_d[i] = s2_q[i];
                fall_d[i] = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
            busy_d = busy_d | (cnt_d[i] != CNT_ZERO);
        end
    end

    // State and registered outputs; reset clears everything, including the synchronizer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= {WIDTH{1'b0}};
            s2_q   <= {WIDTH{1'b0}};
            db_q   <= {WIDTH{1'b0}};
            rise_q <= {WIDTH{1'b0}};
            fall_q <= {WIDTH{1'b0}};
            busy_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s1_q;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            busy_q <= busy_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign db_out     = db_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = busy_q;

endmodule
